// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer backed by a byte-wide register memory.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per transfer.
module apb_slave_mem #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] prdata_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic              pready_d, pslverr_d;
  logic              mem_we;
  logic              addr_err;
  logic              setup;
  logic              abort;
  logic              load_rdy;
  logic [IW-1:0]     rd_idx, wr_idx;

  assign setup    = PSEL && !PENABLE;
  assign abort    = !PSEL || !PENABLE;
  assign addr_err = 32'(PADDR) >= MEM_DEPTH;
  assign rd_idx   = PADDR[IW-1:0];
  assign wr_idx   = addr_q[IW-1:0];

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q, cnt_d;
  assign load_rdy = (WAIT_LD == 4'd0);
`else
  assign load_rdy = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    err_d     = err_q;
    prdata_d  = PRDATA;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    mem_we    = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d   = ACCESS;
          addr_d    = PADDR;
          wdata_d   = PWDATA;
          wr_d      = PWRITE;
          err_d     = addr_err;
          pready_d  = load_rdy;
          pslverr_d = load_rdy && addr_err;
          if (!PWRITE)
            prdata_d = addr_err ? '0 : mem[rd_idx];
`ifdef APB_SLV_WAIT_EN
          cnt_d     = WAIT_LD;
`endif
        end
      end
      ACCESS: begin
        // Abort wins even on the completing edge: no commit without PSEL.
        if (abort) begin
          state_d = IDLE;
        end else if (PREADY) begin
          state_d = IDLE;
          mem_we  = wr_q && !err_q;
        end else begin
`ifdef APB_SLV_WAIT_EN
          cnt_d     = cnt_q - 4'd1;
          pready_d  = (cnt_q == 4'd1);
          pslverr_d = (cnt_q == 4'd1) && err_q;
`else
          state_d   = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      PRDATA  <= prdata_d;
      PREADY  <= pready_d;
      PSLVERR <= pslverr_d;
`ifdef APB_SLV_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < MEM_DEPTH; i++)
        mem[i] <= '0;
    end else if (mem_we) begin
      mem[wr_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed checks of apb_slave_mem.
// Two instances: 256-byte (WAIT_CYCLES=3) and 128-byte (WAIT_CYCLES=2).
module tb_apb_slave_mem;

`ifdef APB_SLV_WAIT_EN
  localparam int W0 = 3;
  localparam int W1 = 2;
`else
  localparam int W0 = 0;
  localparam int W1 = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psel0 = 1'b0;
  logic       psel1 = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = '0;
  logic [7:0] pwdata = '0;
  logic [7:0] prdata0, prdata1;
  logic       pready0, pready1;
  logic       pslverr0, pslverr1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(
    .DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .WAIT_CYCLES(3)
  ) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_slave_mem #(
    .DATA_W(8), .ADDR_W(8), .MEM_DEPTH(128), .WAIT_CYCLES(2)
  ) dut1 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel1), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
  );

  // PSLVERR may only be high together with PREADY.
  always @(negedge clk) begin
    n_checks += 2;
    if (pslverr0 && !pready0) begin
      n_fail++;
      $display("FAIL err_wo_ready0 t=%0t pslverr=1 pready=0 required pslverr=0", $time);
    end
    if (pslverr1 && !pready1) begin
      n_fail++;
      $display("FAIL err_wo_ready1 t=%0t pslverr=1 pready=0 required pslverr=0", $time);
    end
  end

  function automatic logic rdy(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  // Starts at #1 after a rising edge; returns #1 after the completing edge.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                      input logic [7:0] wd, output logic [7:0] rd,
                      output logic err, output int waits);
    if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!rdy(d) && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    n_checks++;
    if (!rdy(d)) begin
      n_fail++;
      $display("FAIL timeout dut%0d addr=%h pready=0 required 1 within 40 cycles", d, a);
    end
    rd  = (d == 0) ? prdata0 : prdata1;
    err = (d == 0) ? pslverr0 : pslverr1;
    @(posedge clk); #1;
    psel0 = 1'b0;
    psel1 = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic err;
    int w;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks += 4;
    if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags0 got rdy=%b err=%b required 0 0", pready0, pslverr0);
    end
    if (prdata0 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_prdata0 got %h required 00", prdata0);
    end
    if (pready1 !== 1'b0 || pslverr1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags1 got rdy=%b err=%b required 0 0", pready1, pslverr1);
    end
    if (prdata1 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_prdata1 got %h required 00", prdata1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(0, 1'b0, 8'h7F, 8'h00, rd, err, w);
    n_checks += 3;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_read got %h required 00", rd);
    end
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read_err got %b required 0", err);
    end
    if (w != W0) begin
      n_fail++;
      $display("FAIL reset_read_wait got %0d required %0d", w, W0);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd;
    logic err;
    int w;
    xfer(0, 1'b1, 8'h10, 8'hA5, rd, err, w);
    n_checks += 2;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_err got %b required 0", err);
    end
    if (w != W0) begin
      n_fail++;
      $display("FAIL wr_wait got %0d required %0d", w, W0);
    end
    xfer(0, 1'b0, 8'h10, 8'h00, rd, err, w);
    n_checks += 3;
    if (rd !== 8'hA5) begin
      n_fail++;
      $display("FAIL rd_data got %h required a5", rd);
    end
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_err got %b required 0", err);
    end
    if (w != W0) begin
      n_fail++;
      $display("FAIL rd_wait got %0d required %0d", w, W0);
    end
    @(negedge clk);
    n_checks += 2;
    if (pready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_drop got %b required 0", pready0);
    end
    if (prdata0 !== 8'hA5) begin
      n_fail++;
      $display("FAIL prdata_hold got %h required a5", prdata0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wait_states();
    logic [7:0] rd;
    logic err;
    int w;
    xfer(0, 1'b1, 8'hFF, 8'h3C, rd, err, w);
    n_checks += 2;
    if (w != W0) begin
      n_fail++;
      $display("FAIL wait_wr got %0d required %0d", w, W0);
    end
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_wr_err got %b required 0", err);
    end
    xfer(0, 1'b0, 8'hFF, 8'h00, rd, err, w);
    n_checks += 2;
    if (rd !== 8'h3C) begin
      n_fail++;
      $display("FAIL wait_rd got %h required 3c", rd);
    end
    if (w != W0) begin
      n_fail++;
      $display("FAIL wait_rd_wait got %0d required %0d", w, W0);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd;
    logic err;
    int w;
    xfer(1, 1'b1, 8'h7F, 8'h11, rd, err, w);
    xfer(1, 1'b0, 8'h7F, 8'h00, rd, err, w);
    n_checks += 2;
    if (rd !== 8'h11 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_top got %h/%b required 11/0", rd, err);
    end
    if (w != W1) begin
      n_fail++;
      $display("FAIL oor_wait got %0d required %0d", w, W1);
    end
    xfer(1, 1'b1, 8'h80, 8'h55, rd, err, w);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_wr_err got %b required 1", err);
    end
    @(negedge clk);
    n_checks++;
    if (pslverr1 !== 1'b0 || pready1 !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_err_drop got %b/%b required 0/0", pready1, pslverr1);
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 8'h80, 8'h00, rd, err, w);
    n_checks += 2;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_rd_err got %b required 1", err);
    end
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_rd_data got %h required 00", rd);
    end
    xfer(1, 1'b0, 8'h00, 8'h00, rd, err, w);
    n_checks += 2;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_alias got %h required 00", rd);
    end
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_zero_err got %b required 0", err);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    logic err;
    int w;
    logic [7:0] addrs [4] = '{8'h00, 8'h01, 8'h7E, 8'h80};
    logic [7:0] datas [4] = '{8'h01, 8'hFE, 8'h5A, 8'hC3};
    for (int i = 0; i < 4; i++)
      xfer(0, 1'b1, addrs[i], datas[i], rd, err, w);
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b0, addrs[i], 8'h00, rd, err, w);
      n_checks += 2;
      if (rd !== datas[i]) begin
        n_fail++;
        $display("FAIL b2b_rd%0d got %h required %h", i, rd, datas[i]);
      end
      if (err !== 1'b0 || w != W0) begin
        n_fail++;
        $display("FAIL b2b_resp%0d got err=%b wait=%0d required 0/%0d", i, err, w, W0);
      end
    end
  endtask

  task automatic test_protocol();
    logic [7:0] rd;
    logic err;
    int w;
    psel0 = 1'b1;
    penable = 1'b1;
    pwrite = 1'b1;
    paddr = 8'h30;
    pwdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (pready0 !== 1'b0) begin
        n_fail++;
        $display("FAIL proto_ready%0d got %b required 0", i, pready0);
      end
    end
    @(posedge clk); #1;
    psel0 = 1'b0;
    penable = 1'b0;
    xfer(0, 1'b0, 8'h30, 8'h00, rd, err, w);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL proto_rd got %h required 00", rd);
    end
  endtask

`ifdef APB_SLV_WAIT_EN
  task automatic test_abort();
    logic [7:0] rd;
    logic err;
    int w;
    psel1 = 1'b1;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h20;
    pwdata = 8'h99;
    @(posedge clk); #1;
    psel1 = 1'b0;
    penable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (pready1 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_ready%0d got %b required 0", i, pready1);
      end
    end
    @(posedge clk); #1;
    penable = 1'b0;
    xfer(1, 1'b0, 8'h20, 8'h00, rd, err, w);
    n_checks++;
    if (rd !== 8'h00 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rd got %h/%b required 00/0", rd, err);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] rd;
    logic err;
    int w;
    psel0 = 1'b1;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h05;
    pwdata = 8'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    psel0 = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_flags got %b/%b required 0/0", pready0, pslverr0);
    end
    @(posedge clk); #1;
    xfer(0, 1'b0, 8'h05, 8'h00, rd, err, w);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_rst_rd got %h required 00", rd);
    end
    xfer(0, 1'b0, 8'hFF, 8'h00, rd, err, w);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_rst_clear got %h required 00", rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_out_of_range();
    test_back_to_back();
    test_protocol();
`ifdef APB_SLV_WAIT_EN
    test_abort();
`endif
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB3 completer that terminates one of the two slave selects decoded by the APB bridge. It is a byte-wide register memory with a wait-state counter and error response. It sits directly downstream of the bridge, which maps bridge address bit 8 to PSEL of slave 0 or slave 1. The block consumes the bridge's setup/access phases and returns the read data and PSLVERR that the bridge forwards to its user side.

## Interface

Parameters:
- DATA_W, 8: PWDATA/PRDATA width.
- ADDR_W, 8: PADDR width; bit 8 of the bridge address is already consumed by slave decode.
- MEM_DEPTH, 256: number of implemented bytes; valid addresses are 0..MEM_DEPTH-1 (1..256).
- WAIT_CYCLES, 2: wait states inserted per transfer; only used when APB_SLV_WAIT_EN is defined (0..15).

Ports:
- PCLK, in, 1: the single clock; all logic is rising-edge.
- PRESET, in, 1: reset, synchronous, active-high.
- PSEL, in, 1: slave select from the bridge.
- PENABLE, in, 1: access-phase indicator.
- PWRITE, in, 1: 1 = write, 0 = read.
- PADDR, in, ADDR_W: byte address.
- PWDATA, in, DATA_W: write data.
- PRDATA, out, DATA_W: read data, valid when PREADY=1 and PWRITE=0.
- PREADY, out, 1: transfer completes in this cycle.
- PSLVERR, out, 1: error response, meaningful only while PREADY=1.

## Operation

- State machine IDLE and ACCESS; all outputs registered.
- Reset (PRESET=1 at an edge):
  - State goes to IDLE; wait counter is 0.
  - PRDATA=0, PREADY=0, PSLVERR=0; all MEM_DEPTH bytes are cleared to 0.
  - A transfer in flight is dropped and no write is committed.
- IDLE:
  - PSEL=1 and PENABLE=0 is a setup cycle. On that edge the block latches PADDR, PWRITE, PWDATA and the error flag (PADDR >= MEM_DEPTH), loads the wait counter, and moves to ACCESS.
  - For reads with a valid address, PRDATA loads mem[PADDR] on the same edge. For error reads PRDATA loads 0.
  - PSEL=1 with PENABLE=1 in IDLE is a protocol violation. It is ignored and the state stays IDLE.
- ACCESS:
  - While the counter is non-zero, PREADY=0 and the counter decrements each cycle.
  - When the counter is 0, PREADY=1 and PSLVERR equals the latched error flag.
  - On the completing edge a valid write commits mem[latched addr] = latched data. Error writes commit nothing.
  - The state then returns to IDLE.
- PADDR, PWRITE and PWDATA changes during ACCESS are ignored; the latched values are used.
- PSEL or PENABLE falling in ACCESS before completion aborts the transfer: go to IDLE, PREADY=0, no write.
- After any completion, PREADY and PSLVERR return to 0 on the next cycle. PRDATA holds its value until the next setup.

## Timing

- Setup at cycle T, zero wait states: PREADY=1 in cycle T+1.
- With N wait states: PREADY=1 in cycle T+1+N; PREADY=0 from T+1 to T+N.
- Write data becomes visible to a read issued in the setup cycle immediately after completion (back-to-back).
- Back-to-back transfers: the bridge's next setup cycle falls in T+2+N, while the block is in IDLE. No dead cycle is required beyond the APB setup phase.
- Throughput: one transfer per 2+N cycles.
- PSLVERR=1 only in the cycle where PREADY=1; it is 0 in every other cycle.

## Configuration

- APB_SLV_WAIT_EN defined: the wait counter is loaded with WAIT_CYCLES at setup, giving WAIT_CYCLES wait states on every transfer.
- APB_SLV_WAIT_EN undefined:
  - The counter logic is removed and WAIT_CYCLES is ignored.
  - PREADY=1 in the first ACCESS cycle, giving zero-wait APB3 behaviour.
  - Abort and error behaviour is unchanged.

## Test plan

- Reset with MEM_DEPTH=256, macro off:
  - Stimulus: drive PRESET=1 for 2 cycles, then read addr 0x7F.
  - Required: PRDATA=0x00, PREADY=1 at T+1, PSLVERR=0.
- Zero-wait write then read, macro off:
  - Stimulus: write 0xA5 to 0x10, then immediately read 0x10.
  - Required: read returns PRDATA=0xA5, PSLVERR=0; each transfer takes 2 cycles.
- Wait states, macro on, WAIT_CYCLES=3:
  - Stimulus: write 0x3C to 0xFF.
  - Required: PREADY=0 for 3 ACCESS cycles, then 1 at T+4; a following read of 0xFF returns 0x3C.
- Out-of-range address, MEM_DEPTH=128:
  - Stimulus: write 0x55 to 0x80, then read 0x80, then read 0x00.
  - Required: the write and first read give PREADY=1 with PSLVERR=1; the read gives PRDATA=0x00 and 0x00 is unmodified. The read of 0x00 gives PSLVERR=0.
- Abort, macro on, WAIT_CYCLES=2:
  - Stimulus: write 0x99 to 0x20, drop PSEL in the first ACCESS cycle, then read 0x20.
  - Required: the read returns the prior value 0x00 and no PREADY pulse occurs for the aborted transfer.
- Reset mid-transfer:
  - Stimulus: assert PRESET during the ACCESS of a write of 0x77 to 0x05.
  - Required: PREADY=0, PSLVERR=0 the next cycle; a later read of 0x05 returns 0x00.
